vending_fsm_param: RTL and testbench

Parametrised successor to the board-level drink vending FSM. It keeps a saturating credit counter fed by a coin button and supports N_PROD products with individual prices. It holds the dispense output for a programmable number of slow ticks, then pays out leftover credit as change pulses. Everything runs in the single clk domain; the slow tick is an internal clock enable, not a derived clock.

---
 rtl/vending_fsm_param.sv | 212 +++++++++++++++++++++
 tb/tb_vending_fsm_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_fsm_param.sv
// Parametrised drink vending controller. Buttons are synchronised and
// edge-detected, credit saturates at MAX_CREDIT, each product has its own
// price, dispense is held for HOLD_TICKS slow ticks and leftover credit is
// paid back one change pulse per tick. The slow tick is a clock enable.
module vending_fsm_param #(
  parameter int                         CREDIT_W    = 4,
  parameter int                         MAX_CREDIT  = 9,
  parameter int                         N_PROD      = 3,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES      = {4'd3, 4'd2, 4'd1},
  parameter int                         TICK_CYCLES = 50_000_000,
  parameter int                         HOLD_TICKS  = 2,
  parameter int                         AUTO_CHANGE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_coin,
  input  logic [N_PROD-1:0]   btn_sel,
  input  logic                btn_cancel,
  output logic [N_PROD-1:0]   dispense,
  output logic                change_pulse,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                sel_nack
);

  localparam int N_BTN = N_PROD + 2;
  localparam int TW    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HW    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int IW    = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  localparam logic [TW-1:0]       TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [HW-1:0]       HOLD_LAST   = HW'(HOLD_TICKS - 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX  = CREDIT_W'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] CREDIT_ZERO = {CREDIT_W{1'b0}};
  localparam logic [CREDIT_W-1:0] CREDIT_ONE  = CREDIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VEND   = 2'd1,
    S_CHANGE = 2'd2
  } state_t;

  // registered state
  logic [N_BTN-1:0]    btn_meta_r, btn_sync_r, btn_prev_r;
  state_t              state_r;
  logic [CREDIT_W-1:0] credit_r;
  logic [N_PROD-1:0]   dispense_r;
  logic                change_pulse_r, busy_r, coin_reject_r, sel_nack_r;
  logic                cancel_pend_r;
  logic [TW-1:0]       tick_cnt_r;
  logic [HW-1:0]       hold_cnt_r;

  // event decode and datapath
  logic [N_BTN-1:0]    btn_ev_s;
  logic                coin_ev_s, cancel_ev_s, tick_s;
  logic [N_PROD-1:0]   sel_ev_s, sel_onehot_s;
  logic                sel_hit_s;
  logic [IW-1:0]       sel_idx_s;
  logic [CREDIT_W-1:0] sel_price_s, base_credit_s, credit_coin_s;
  logic                cancel_go_s, vend_ok_s, coin_acc_s;

  // next-state values
  state_t              state_nxt_s;
  logic [CREDIT_W-1:0] credit_nxt_s;
  logic [N_PROD-1:0]   dispense_nxt_s;
  logic                change_nxt_s, reject_nxt_s, nack_nxt_s, pend_nxt_s;
  logic [TW-1:0]       tick_nxt_s;
  logic [HW-1:0]       hold_nxt_s;

  // Two-flop synchroniser plus previous-value flop for rising-edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_r <= {N_BTN{1'b0}};
      btn_sync_r <= {N_BTN{1'b0}};
      btn_prev_r <= {N_BTN{1'b0}};
    end else begin
      btn_meta_r <= {btn_cancel, btn_sel, btn_coin};
      btn_sync_r <= btn_meta_r;
      btn_prev_r <= btn_sync_r;
    end
  end

  assign btn_ev_s    = btn_sync_r & ~btn_prev_r;
  assign coin_ev_s   = btn_ev_s[0];
  assign sel_ev_s    = btn_ev_s[N_PROD:1];
  assign cancel_ev_s = btn_ev_s[N_PROD+1];
  assign tick_s      = (tick_cnt_r == TICK_LAST);

  // Lowest-index select strobe wins: scan downwards so index 0 is written last.
  always_comb begin
    sel_hit_s = 1'b0;
    sel_idx_s = {IW{1'b0}};
    for (int i = N_PROD - 1; i >= 0; i--) begin
      sel_hit_s = sel_hit_s | sel_ev_s[i];
      sel_idx_s = sel_ev_s[i] ? IW'(i) : sel_idx_s;
    end
  end

  assign sel_price_s  = PRICES[int'(sel_idx_s) * CREDIT_W +: CREDIT_W];
  assign sel_onehot_s = N_PROD'(1'b1) << sel_idx_s;

  // A coin always makes credit non-zero (MAX_CREDIT >= 1), so a cancel that
  // arrives with a coin is honoured even from zero credit.
  assign cancel_go_s   = cancel_ev_s && ((credit_r != CREDIT_ZERO) || coin_ev_s);
  // Price is compared against the pre-event credit; the coin lands afterwards.
  assign vend_ok_s     = (state_r == S_IDLE) && !cancel_go_s && sel_hit_s &&
                         (credit_r >= sel_price_s);
  assign base_credit_s = vend_ok_s ? (credit_r - sel_price_s) : credit_r;
  assign coin_acc_s    = coin_ev_s && (state_r != S_CHANGE) && (base_credit_s < CREDIT_MAX);
  assign credit_coin_s = coin_acc_s ? (base_credit_s + CREDIT_ONE) : base_credit_s;

  // Next-state, credit and output decode for the IDLE / VEND / CHANGE machine.
  always_comb begin
    state_nxt_s    = state_r;
    credit_nxt_s   = credit_coin_s;
    dispense_nxt_s = dispense_r;
    change_nxt_s   = 1'b0;
    reject_nxt_s   = coin_ev_s & ~coin_acc_s;
    nack_nxt_s     = 1'b0;
    pend_nxt_s     = cancel_pend_r;
    hold_nxt_s     = hold_cnt_r;
    tick_nxt_s     = tick_s ? {TW{1'b0}} : (tick_cnt_r + TW'(1));
    case (state_r)
      S_IDLE: begin
        if (cancel_go_s) begin
          state_nxt_s = S_CHANGE;
          tick_nxt_s  = {TW{1'b0}};
        end else if (vend_ok_s) begin
          state_nxt_s    = S_VEND;
          dispense_nxt_s = sel_onehot_s;
          hold_nxt_s     = {HW{1'b0}};
          tick_nxt_s     = {TW{1'b0}};
        end else begin
          nack_nxt_s = sel_hit_s;
        end
      end
      S_VEND: begin
        pend_nxt_s = cancel_pend_r | cancel_ev_s;
        if (tick_s && (hold_cnt_r == HOLD_LAST)) begin
          dispense_nxt_s = {N_PROD{1'b0}};
          pend_nxt_s     = 1'b0;
          if ((credit_coin_s != CREDIT_ZERO) &&
              ((AUTO_CHANGE != 0) || cancel_pend_r || cancel_ev_s)) begin
            state_nxt_s = S_CHANGE;
            tick_nxt_s  = {TW{1'b0}};
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else if (tick_s) begin
          hold_nxt_s = hold_cnt_r + HW'(1);
        end else begin
          hold_nxt_s = hold_cnt_r;
        end
      end
      S_CHANGE: begin
        if (tick_s) begin
          if (credit_r != CREDIT_ZERO) begin
            credit_nxt_s = credit_r - CREDIT_ONE;
            change_nxt_s = 1'b1;
          end else begin
            credit_nxt_s = credit_r;
          end
          state_nxt_s = (credit_r <= CREDIT_ONE) ? S_IDLE : S_CHANGE;
        end else begin
          credit_nxt_s = credit_r;
        end
      end
      default: begin
        state_nxt_s    = S_IDLE;
        credit_nxt_s   = CREDIT_ZERO;
        dispense_nxt_s = {N_PROD{1'b0}};
        pend_nxt_s     = 1'b0;
      end
    endcase
  end

  // State, credit and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      credit_r       <= CREDIT_ZERO;
      dispense_r     <= {N_PROD{1'b0}};
      change_pulse_r <= 1'b0;
      busy_r         <= 1'b0;
      coin_reject_r  <= 1'b0;
      sel_nack_r     <= 1'b0;
      cancel_pend_r  <= 1'b0;
      tick_cnt_r     <= {TW{1'b0}};
      hold_cnt_r     <= {HW{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      credit_r       <= credit_nxt_s;
      dispense_r     <= dispense_nxt_s;
      change_pulse_r <= change_nxt_s;
      busy_r         <= (state_nxt_s != S_IDLE);
      coin_reject_r  <= reject_nxt_s;
      sel_nack_r     <= nack_nxt_s;
      cancel_pend_r  <= pend_nxt_s;
      tick_cnt_r     <= tick_nxt_s;
      hold_cnt_r     <= hold_nxt_s;
    end
  end

  assign dispense     = dispense_r;
  assign change_pulse = change_pulse_r;
  assign credit       = credit_r;
  assign busy         = busy_r;
  assign coin_reject  = coin_reject_r;
  assign sel_nack     = sel_nack_r;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Self-checking bench for vending_fsm_param with a 4-cycle slow tick.
// dut_a runs with automatic change, dut_b keeps credit until cancel.
module tb_vending_fsm_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       coin_a, cancel_a, chg_a, busy_a, rej_a, nack_a;
  logic [2:0] sel_a, disp_a;
  logic [3:0] credit_a;
  logic       coin_b, cancel_b, chg_b, busy_b, rej_b, nack_b;
  logic [2:0] sel_b, disp_b;
  logic [3:0] credit_b;

  vending_fsm_param #(.CREDIT_W(4), .MAX_CREDIT(9), .N_PROD(3), .PRICES(12'h321),
                      .TICK_CYCLES(4), .HOLD_TICKS(2), .AUTO_CHANGE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_coin(coin_a), .btn_sel(sel_a), .btn_cancel(cancel_a),
    .dispense(disp_a), .change_pulse(chg_a), .credit(credit_a), .busy(busy_a),
    .coin_reject(rej_a), .sel_nack(nack_a));

  vending_fsm_param #(.CREDIT_W(4), .MAX_CREDIT(9), .N_PROD(3), .PRICES(12'h321),
                      .TICK_CYCLES(4), .HOLD_TICKS(2), .AUTO_CHANGE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_coin(coin_b), .btn_sel(sel_b), .btn_cancel(cancel_b),
    .dispense(disp_b), .change_pulse(chg_b), .credit(credit_b), .busy(busy_b),
    .coin_reject(rej_b), .sel_nack(nack_b));

  typedef struct {
    logic       coin;
    logic [2:0] sel;
    logic       cancel;
    int         hold;
    int         settle;
    int         credit;
    int         disp;
    int         busy;
    int         nack;
    int         rej;
    int         chg;
  } vec_t;

  typedef struct {
    int credit;
    int disp;
    int busy;
    int nack;
    int rej;
    int chg;
  } obs_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic [2:0] s, input logic x,
                              input int hold, input int settle, input int cr,
                              input int d, input int b, input int n, input int r,
                              input int ch);
    vec_t v;
    v.coin = c; v.sel = s; v.cancel = x; v.hold = hold; v.settle = settle;
    v.credit = cr; v.disp = d; v.busy = b; v.nack = n; v.rej = r; v.chg = ch;
    return v;
  endfunction

  task automatic drive(input bit b, input logic c, input logic [2:0] s, input logic x);
    if (b) begin
      coin_b = c; sel_b = s; cancel_b = x;
    end else begin
      coin_a = c; sel_a = s; cancel_a = x;
    end
  endtask

  // Called on a falling edge: press, release after 'hold' edges, sample after 'settle' more.
  task automatic run(input bit b, input logic c, input logic [2:0] s, input logic x,
                     input int hold, input int settle, output obs_t o);
    o.nack = 0; o.rej = 0; o.chg = 0;
    drive(b, c, s, x);
    for (int i = 1; i <= hold + settle; i++) begin
      @(negedge clk);
      if (i == hold) drive(b, 1'b0, 3'b000, 1'b0);
      if (b ? nack_b : nack_a) o.nack++;
      if (b ? rej_b  : rej_a)  o.rej++;
      if (b ? chg_b  : chg_a)  o.chg++;
    end
    o.credit = b ? int'(credit_b) : int'(credit_a);
    o.disp   = b ? int'(disp_b)   : int'(disp_a);
    o.busy   = b ? int'(busy_b)   : int'(busy_a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    vec_t e;
    int   first, dcnt, pcnt, pidx, prev;

    // ---------------- reset and asynchronous reset mid-VEND ----------------
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset credit", credit_a, 0);
    check("reset dispense", disp_a, 0);
    check("reset busy", busy_a, 0);
    check("reset credit b", credit_b, 0);

    run(1'b0, 1'b1, 3'b000, 1'b0, 2, 2, o);
    run(1'b0, 1'b1, 3'b000, 1'b0, 2, 2, o);
    run(1'b0, 1'b0, 3'b001, 1'b0, 2, 3, o);
    check("pre-reset dispense", disp_a, 1);
    check("pre-reset credit", credit_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset dispense", disp_a, 0);
    check("async reset credit", credit_a, 0);
    check("async reset busy", busy_a, 0);
    check("async reset pulses", {chg_a, rej_a, nack_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- table-driven vectors on dut_a ----------------
    //               coin sel     cxl hold settle cred disp busy nack rej chg
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 2, 3,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 2, 3,  2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 2, 3,  3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, 3'b010, 1'b0, 2, 4,  1, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1'b0, 3'b000, 1'b0, 2, 10, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1'b0, 3'b000, 1'b1, 2, 3,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 2, 3,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, 3'b100, 1'b0, 10, 3, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1'b0, 3'b000, 1'b1, 2, 12, 0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(1'b1, 3'b000, 1'b0, 2, 2, k, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 2, 2,  9, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1'b0, 3'b000, 1'b1, 2, 2,  9, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 2, 2,  8, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1'b0, 3'b000, 1'b0, 2, 40, 0, 0, 0, 0, 0, 8));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 2, 3,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 3'b001, 1'b0, 2, 3,  1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1'b0, 3'b000, 1'b0, 2, 20, 0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(1'b1, 3'b000, 1'b0, 2, 2, k, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b0, 3'b101, 1'b0, 2, 3,  4, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1'b0, 3'b000, 1'b0, 2, 35, 0, 0, 0, 0, 0, 4));

    for (int k = 0; k < tbl.size(); k++) begin
      sb.push_back(tbl[k]);
      run(1'b0, tbl[k].coin, tbl[k].sel, tbl[k].cancel, tbl[k].hold, tbl[k].settle, o);
      e = sb.pop_front();
      check($sformatf("row%0d credit", k),   o.credit, e.credit);
      check($sformatf("row%0d dispense", k), o.disp,   e.disp);
      check($sformatf("row%0d busy", k),     o.busy,   e.busy);
      check($sformatf("row%0d nack", k),     o.nack,   e.nack);
      check($sformatf("row%0d reject", k),   o.rej,    e.rej);
      check($sformatf("row%0d change", k),   o.chg,    e.chg);
    end

    // ---------------- exact dispense / change timing on dut_a ----------------
    for (int k = 0; k < 3; k++) run(1'b0, 1'b1, 3'b000, 1'b0, 2, 2, o);
    check("timing credit before select", credit_a, 3);
    drive(1'b0, 1'b0, 3'b010, 1'b0);
    first = -1; dcnt = 0; pcnt = 0; pidx = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) drive(1'b0, 1'b0, 3'b000, 1'b0);
      if (disp_a == 3'b010) begin
        dcnt++;
        if (first < 0) first = i;
      end
      if (chg_a) begin
        pcnt++;
        pidx = i;
      end
      if (i == 3)  check("timing credit in vend", credit_a, 1);
      if (i == 14) check("timing busy before tick", busy_a, 1);
      if (i == 15) check("timing busy after change", busy_a, 0);
    end
    check("timing dispense first cycle", first, 3);
    check("timing dispense cycles", dcnt, 8);
    check("timing change pulses", pcnt, 1);
    check("timing change offset", pidx - first, 12);
    check("timing final credit", credit_a, 0);

    // ---------------- AUTO_CHANGE=0 on dut_b ----------------
    for (int k = 0; k < 5; k++) run(1'b1, 1'b1, 3'b000, 1'b0, 2, 2, o);
    check("b credit after coins", credit_b, 5);
    run(1'b1, 1'b0, 3'b001, 1'b0, 2, 20, o);
    check("b kept credit", o.credit, 4);
    check("b idle after vend", o.busy, 0);
    check("b no auto change", o.chg, 0);
    check("b dispense cleared", o.disp, 0);

    drive(1'b1, 1'b0, 3'b000, 1'b1);
    pcnt = 0; prev = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 2) drive(1'b1, 1'b0, 3'b000, 1'b0);
      if (chg_b) begin
        pcnt++;
        if (prev < 0) check("b first change cycle", i, 7);
        else          check($sformatf("b change spacing %0d", pcnt), i - prev, 4);
        prev = i;
      end
    end
    check("b change pulse count", pcnt, 4);
    check("b credit after change", credit_b, 0);
    check("b busy after change", busy_b, 0);

    for (int k = 0; k < 3; k++) run(1'b1, 1'b1, 3'b000, 1'b0, 2, 2, o);
    drive(1'b1, 1'b0, 3'b001, 1'b0);
    pcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 2) drive(1'b1, 1'b0, 3'b000, 1'b0);
      if (i == 4) drive(1'b1, 1'b0, 3'b000, 1'b1);
      if (i == 6) drive(1'b1, 1'b0, 3'b000, 1'b0);
      if (chg_b) pcnt++;
      if (i == 8)  check("b cancel-in-vend dispense", disp_b, 1);
      if (i == 8)  check("b cancel-in-vend credit", credit_b, 2);
      if (i == 12) check("b change follows vend", busy_b, 1);
      if (i == 12) check("b dispense off in change", disp_b, 0);
    end
    check("b cancel-in-vend pulses", pcnt, 2);
    check("b cancel-in-vend final credit", credit_b, 0);
    check("b cancel-in-vend idle", busy_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
